// File: rtl/regfile_io_write_scheduler.sv
// Shares the single regfile write port between CPU writeback and switch/button mirroring.
// The CPU always wins; idle slots refresh regs 26/27/28 round-robin, with a stall on starvation.
module regfile_io_write_scheduler #(
    parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000,
    parameter int unsigned MAX_WAIT        = 8,
    parameter logic [4:0]  SWL_REG         = 5'd26,
    parameter logic [4:0]  SWH_REG         = 5'd27,
    parameter logic [4:0]  BTN_REG         = 5'd28
) (
    input  logic        clock,
    input  logic        ctrl_reset,
    input  logic        cpu_we,
    input  logic [4:0]  cpu_wreg,
    input  logic [31:0] cpu_wdata,
    input  logic [15:0] SW,
    input  logic        BTNR,
    output logic        rf_we,
    output logic [4:0]  rf_wreg,
    output logic [31:0] rf_wdata,
    output logic        cpu_stall,
    output logic [2:0]  io_pending,
    output logic        proto_err
);
    localparam int WW = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
    localparam logic [WW-1:0] WAIT_LAST = WW'(MAX_WAIT - 1);
    localparam logic [15:0] DB_LAST = DEBOUNCE_CYCLES - 16'd1;

    logic [15:0]   sw_m, sw_s;
    logic          btn_m, btn_s, btn_db;
    logic [15:0]   db_cnt;
    logic [7:0]    shadow_swl, shadow_swh;
    logic          shadow_btn;
    logic [2:0]    valid;
    logic [1:0]    rr_ptr;
    logic [WW-1:0] wait_cnt;
    logic          grant_vld;
    logic [1:0]    grant_idx;
    logic [7:0]    grant_val;

    // rr_ptr never exceeds 2, so a single conditional subtract wraps the sum
    function automatic logic [1:0] rr_add(input logic [1:0] base, input logic [1:0] off);
        logic [2:0] s;
        s = {1'b0, base} + {1'b0, off};
        return (s >= 3'd3) ? 2'(s - 3'd3) : s[1:0];
    endfunction

    assign io_pending[0] = !valid[0] || (sw_s[7:0]  != shadow_swl);
    assign io_pending[1] = !valid[1] || (sw_s[15:8] != shadow_swh);
    assign io_pending[2] = !valid[2] || (btn_db     != shadow_btn);

    // Walk from farthest to nearest so the first pending bit after rr_ptr wins
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = 2'd0;
        if (!cpu_we) begin
            for (int i = 2; i >= 0; i--) begin
                if (io_pending[rr_add(rr_ptr, 2'(i))]) begin
                    grant_vld = 1'b1;
                    grant_idx = rr_add(rr_ptr, 2'(i));
                end
            end
        end
    end

    always_comb begin
        case (grant_idx)
            2'd0:    grant_val = sw_s[7:0];
            2'd1:    grant_val = sw_s[15:8];
            default: grant_val = {7'd0, btn_db};
        endcase
    end

    // Port outputs are forced idle while reset is held so nothing reaches the regfile
    always_comb begin
        rf_we    = 1'b0;
        rf_wreg  = 5'd0;
        rf_wdata = 32'd0;
        if (ctrl_reset) begin
            if (cpu_we) begin
                rf_we    = 1'b1;
                rf_wreg  = cpu_wreg;
                rf_wdata = cpu_wdata;
            end else if (grant_vld) begin
                rf_we    = 1'b1;
                rf_wdata = {24'd0, grant_val};
                case (grant_idx)
                    2'd0:    rf_wreg = SWL_REG;
                    2'd1:    rf_wreg = SWH_REG;
                    default: rf_wreg = BTN_REG;
                endcase
            end
        end
    end

    always_ff @(posedge clock or negedge ctrl_reset) begin
        if (!ctrl_reset) begin
            sw_m       <= 16'd0;
            sw_s       <= 16'd0;
            btn_m      <= 1'b0;
            btn_s      <= 1'b0;
            btn_db     <= 1'b0;
            db_cnt     <= 16'd0;
            shadow_swl <= 8'd0;
            shadow_swh <= 8'd0;
            shadow_btn <= 1'b0;
            valid      <= 3'b111;
            rr_ptr     <= 2'd0;
            wait_cnt   <= '0;
            cpu_stall  <= 1'b0;
            proto_err  <= 1'b0;
        end else begin
            sw_m  <= SW;
            sw_s  <= sw_m;
            btn_m <= BTNR;
            btn_s <= btn_m;

            if (btn_s == btn_db) begin
                db_cnt <= 16'd0;
            end else if (db_cnt == DB_LAST) begin
                btn_db <= btn_s;
                db_cnt <= 16'd0;
            end else begin
                db_cnt <= db_cnt + 16'd1;
            end

            if (grant_vld) begin
                case (grant_idx)
                    2'd0:    shadow_swl <= sw_s[7:0];
                    2'd1:    shadow_swh <= sw_s[15:8];
                    default: shadow_btn <= btn_db;
                endcase
                valid[grant_idx] <= 1'b1;
                rr_ptr <= (grant_idx == 2'd2) ? 2'd0 : grant_idx + 2'd1;
            end

            // A CPU write over a mirrored register invalidates it so it gets restored
            if (cpu_we) begin
                if (cpu_wreg == SWL_REG) valid[0] <= 1'b0;
                if (cpu_wreg == SWH_REG) valid[1] <= 1'b0;
                if (cpu_wreg == BTN_REG) valid[2] <= 1'b0;
            end

            if (grant_vld || io_pending == 3'd0) begin
                wait_cnt <= '0;
            end else if (wait_cnt != WAIT_LAST) begin
                wait_cnt <= wait_cnt + 1'b1;
            end

            if (grant_vld) begin
                cpu_stall <= 1'b0;
            end else if (io_pending != 3'd0 && wait_cnt == WAIT_LAST) begin
                cpu_stall <= 1'b1;
            end

            if (cpu_we && cpu_stall) proto_err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_regfile_io_write_scheduler.sv
// Bench for regfile_io_write_scheduler: directed table, corner sequences and a
// randomized run checked cycle by cycle against a rule-level reference model.
module tb_regfile_io_write_scheduler;
    localparam int DEB = 16;
    localparam int MAXW = 8;

    logic        clock = 1'b0;
    logic        ctrl_reset = 1'b0;
    logic        cpu_we = 1'b0;
    logic [4:0]  cpu_wreg = 5'd0;
    logic [31:0] cpu_wdata = 32'd0;
    logic [15:0] SW = 16'd0;
    logic        BTNR = 1'b0;
    logic        rf_we;
    logic [4:0]  rf_wreg;
    logic [31:0] rf_wdata;
    logic        cpu_stall;
    logic [2:0]  io_pending;
    logic        proto_err;

    int n_checks = 0;
    int n_errors = 0;

    regfile_io_write_scheduler #(
        .DEBOUNCE_CYCLES(16'(DEB)),
        .MAX_WAIT(MAXW),
        .SWL_REG(5'd26),
        .SWH_REG(5'd27),
        .BTN_REG(5'd28)
    ) dut (
        .clock(clock), .ctrl_reset(ctrl_reset),
        .cpu_we(cpu_we), .cpu_wreg(cpu_wreg), .cpu_wdata(cpu_wdata),
        .SW(SW), .BTNR(BTNR),
        .rf_we(rf_we), .rf_wreg(rf_wreg), .rf_wdata(rf_wdata),
        .cpu_stall(cpu_stall), .io_pending(io_pending), .proto_err(proto_err)
    );

    always #5 clock = ~clock;

    // Reference model state: two-stage input delay, debounced button, per-register mirror
    int m_sw_p1, m_sw_s;
    bit m_btn_p1, m_btn_s, m_btn_db;
    int m_db_run;
    int m_shadow[3];
    bit m_valid[3];
    int m_rr;
    int m_starve;
    bit m_stall, m_perr;
    int e_g, e_pend;

    logic        obs_we;
    logic [4:0]  obs_wreg;
    logic [31:0] obs_wdata;
    logic [2:0]  obs_pend;
    logic        obs_stall, obs_perr;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int cur_val(input int k);
        if (k == 0) return m_sw_s & 'hFF;
        if (k == 1) return (m_sw_s >> 8) & 'hFF;
        return int'(m_btn_db);
    endfunction

    task automatic model_reset();
        m_sw_p1 = 0; m_sw_s = 0;
        m_btn_p1 = 0; m_btn_s = 0; m_btn_db = 0; m_db_run = 0;
        for (int k = 0; k < 3; k++) begin
            m_shadow[k] = 0;
            m_valid[k] = 1;
        end
        m_rr = 0; m_starve = 0; m_stall = 0; m_perr = 0;
    endtask

    // Expected port view for this cycle, given the current inputs
    task automatic model_eval(output bit x_we, output int x_wreg, output int x_wdata);
        e_pend = 0;
        for (int k = 0; k < 3; k++)
            if (!m_valid[k] || cur_val(k) != m_shadow[k]) e_pend |= (1 << k);
        e_g = -1;
        if (!cpu_we) begin
            for (int j = 0; j < 3; j++) begin
                int k;
                k = (m_rr + j) % 3;
                if (e_g < 0 && ((e_pend >> k) & 1) == 1) e_g = k;
            end
        end
        if (cpu_we) begin
            x_we = 1; x_wreg = int'(cpu_wreg); x_wdata = int'(cpu_wdata);
        end else if (e_g >= 0) begin
            x_we = 1; x_wreg = 26 + e_g; x_wdata = cur_val(e_g);
        end else begin
            x_we = 0; x_wreg = 0; x_wdata = 0;
        end
    endtask

    // State update at the clock edge, from the inputs and decision of this cycle
    task automatic model_commit(input bit s_we, input int s_wreg, input logic [15:0] s_sw, input bit s_btn);
        if (s_we && m_stall) m_perr = 1;
        if (e_g >= 0) begin
            m_shadow[e_g] = cur_val(e_g);
            m_valid[e_g] = 1;
            m_rr = (e_g + 1) % 3;
        end
        if (s_we && s_wreg >= 26 && s_wreg <= 28) m_valid[s_wreg - 26] = 0;
        if (e_pend != 0 && e_g < 0) begin
            m_starve++;
            if (m_starve >= MAXW) m_stall = 1;
        end else begin
            m_starve = 0;
        end
        if (e_g >= 0) m_stall = 0;
        if (m_btn_s == m_btn_db) begin
            m_db_run = 0;
        end else begin
            m_db_run++;
            if (m_db_run == DEB) begin
                m_btn_db = m_btn_s;
                m_db_run = 0;
            end
        end
        m_sw_s = m_sw_p1; m_sw_p1 = int'(s_sw);
        m_btn_s = m_btn_p1; m_btn_p1 = s_btn;
    endtask

    task automatic step(input bit we, input logic [4:0] wreg, input logic [31:0] wdata,
                        input logic [15:0] sw, input bit btn);
        bit x_we;
        int x_wreg, x_wdata;
        cpu_we = we; cpu_wreg = wreg; cpu_wdata = wdata; SW = sw; BTNR = btn;
        @(negedge clock);
        obs_we = rf_we; obs_wreg = rf_wreg; obs_wdata = rf_wdata;
        obs_pend = io_pending; obs_stall = cpu_stall; obs_perr = proto_err;
        model_eval(x_we, x_wreg, x_wdata);
        check("rf_we", 32'(obs_we), 32'(x_we));
        check("rf_wreg", 32'(obs_wreg), 32'(x_wreg));
        check("rf_wdata", obs_wdata, 32'(x_wdata));
        check("io_pending", 32'(obs_pend), 32'(e_pend));
        check("cpu_stall", 32'(obs_stall), 32'(m_stall));
        check("proto_err", 32'(obs_perr), 32'(m_perr));
        @(posedge clock);
        model_commit(we, int'(wreg), sw, btn);
        #1;
    endtask

    task automatic do_reset();
        ctrl_reset = 1'b0;
        cpu_we = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        ctrl_reset = 1'b1;
        model_reset();
    endtask

    typedef struct {
        bit          we;
        logic [4:0]  wreg;
        logic [31:0] wdata;
        logic [15:0] sw;
        bit          e_we;
        logic [4:0]  e_wreg;
        logic [31:0] e_wdata;
        logic [2:0]  e_pend;
    } vec_t;

    vec_t tbl[15];

    initial begin
        int first28, n28;
        bit rb, rwe;
        logic [15:0] rsw;
        int burst;

        tbl[0]  = '{1, 5'd5,  32'hDEADBEEF, 16'h0000, 1, 5'd5,  32'hDEADBEEF, 3'b000};
        tbl[1]  = '{0, 5'd0,  32'h0,        16'h0000, 0, 5'd0,  32'h0,        3'b000};
        tbl[2]  = '{1, 5'd26, 32'h1234,     16'h0000, 1, 5'd26, 32'h1234,     3'b000};
        tbl[3]  = '{0, 5'd0,  32'h0,        16'h0000, 1, 5'd26, 32'h0,        3'b001};
        tbl[4]  = '{0, 5'd0,  32'h0,        16'h00FF, 0, 5'd0,  32'h0,        3'b000};
        tbl[5]  = '{0, 5'd0,  32'h0,        16'h00FF, 0, 5'd0,  32'h0,        3'b000};
        tbl[6]  = '{0, 5'd0,  32'h0,        16'h00FF, 1, 5'd26, 32'hFF,       3'b001};
        tbl[7]  = '{0, 5'd0,  32'h0,        16'h00FF, 0, 5'd0,  32'h0,        3'b000};
        tbl[8]  = '{1, 5'd27, 32'h55,       16'h00FF, 1, 5'd27, 32'h55,       3'b000};
        tbl[9]  = '{0, 5'd0,  32'h0,        16'h00FF, 1, 5'd27, 32'h0,        3'b010};
        tbl[10] = '{0, 5'd0,  32'h0,        16'h00FF, 0, 5'd0,  32'h0,        3'b000};
        tbl[11] = '{1, 5'd28, 32'h7,        16'h00FF, 1, 5'd28, 32'h7,        3'b000};
        tbl[12] = '{1, 5'd3,  32'h9,        16'h00FF, 1, 5'd3,  32'h9,        3'b100};
        tbl[13] = '{0, 5'd0,  32'h0,        16'h00FF, 1, 5'd28, 32'h0,        3'b100};
        tbl[14] = '{0, 5'd0,  32'h0,        16'h00FF, 0, 5'd0,  32'h0,        3'b000};

        do_reset();
        for (int i = 0; i < 15; i++) begin
            step(tbl[i].we, tbl[i].wreg, tbl[i].wdata, tbl[i].sw, 1'b0);
            check($sformatf("tbl%0d rf_we", i), 32'(obs_we), 32'(tbl[i].e_we));
            check($sformatf("tbl%0d rf_wreg", i), 32'(obs_wreg), 32'(tbl[i].e_wreg));
            check($sformatf("tbl%0d rf_wdata", i), obs_wdata, tbl[i].e_wdata);
            check($sformatf("tbl%0d io_pending", i), 32'(obs_pend), 32'(tbl[i].e_pend));
        end

        // Quiet after reset
        do_reset();
        check("reset rf_we", 32'(rf_we), 32'd0);
        check("reset stall", 32'(cpu_stall), 32'd0);
        for (int i = 0; i < 20; i++) step(0, 5'd0, 32'd0, 16'h0000, 0);
        check("idle rf_we", 32'(obs_we), 32'd0);
        check("idle pending", 32'(obs_pend), 32'd0);

        // Switch mirroring order after synchronisation
        step(0, 5'd0, 32'd0, 16'hA55A, 0);
        step(0, 5'd0, 32'd0, 16'hA55A, 0);
        step(0, 5'd0, 32'd0, 16'hA55A, 0);
        check("swl wreg", 32'(obs_wreg), 32'd26);
        check("swl data", obs_wdata, 32'h5A);
        step(0, 5'd0, 32'd0, 16'hA55A, 0);
        check("swh wreg", 32'(obs_wreg), 32'd27);
        check("swh data", obs_wdata, 32'hA5);
        step(0, 5'd0, 32'd0, 16'hA55A, 0);
        check("sw settled pending", 32'(obs_pend), 32'd0);

        // Button glitch is rejected, held level is accepted after DEB synced cycles
        n28 = 0;
        first28 = -1;
        for (int i = 0; i < 10; i++) begin
            step(0, 5'd0, 32'd0, 16'hA55A, 1);
            if (obs_we && obs_wreg == 5'd28) n28++;
        end
        for (int i = 0; i < 5; i++) begin
            step(0, 5'd0, 32'd0, 16'hA55A, 0);
            if (obs_we && obs_wreg == 5'd28) n28++;
        end
        check("btn glitch writes", 32'(n28), 32'd0);
        for (int i = 1; i <= 25; i++) begin
            step(0, 5'd0, 32'd0, 16'hA55A, 1);
            if (obs_we && obs_wreg == 5'd28) begin
                n28++;
                if (first28 < 0) first28 = i;
                check("btn data", obs_wdata, 32'd1);
            end
        end
        check("btn write count", 32'(n28), 32'd1);
        check("btn write cycle", 32'(first28), 32'd19);

        // Starvation: stall after MAXW starved cycles, protocol error, recovery
        do_reset();
        for (int i = 0; i < 10; i++) step(1, 5'd5, 32'd1, 16'h0100, 0);
        check("stall not yet", 32'(obs_stall), 32'd0);
        step(1, 5'd5, 32'd2, 16'h0100, 0);
        check("stall raised", 32'(obs_stall), 32'd1);
        check("cpu wins under stall", obs_wdata, 32'd2);
        step(0, 5'd0, 32'd0, 16'h0100, 0);
        check("proto_err sticky", 32'(obs_perr), 32'd1);
        check("io grant wreg", 32'(obs_wreg), 32'd27);
        check("io grant data", obs_wdata, 32'd1);
        check("stall cleared", 32'(cpu_stall), 32'd0);

        // CPU overwrite of a mirrored register is restored at the next idle slot
        step(1, 5'd27, 32'h1234, 16'h0100, 0);
        check("cpu to reg27", obs_wdata, 32'h1234);
        step(0, 5'd0, 32'd0, 16'h0100, 0);
        check("restore wreg", 32'(obs_wreg), 32'd27);
        check("restore data", obs_wdata, 32'd1);
        step(0, 5'd0, 32'd0, 16'h0100, 0);
        check("restore done", 32'(obs_pend), 32'd0);

        // Asynchronous reset while stalled
        for (int i = 0; i < 11; i++) step(1, 5'd5, 32'd3, 16'h0300, 0);
        check("stall before reset", 32'(cpu_stall), 32'd1);
        check("perr before reset", 32'(proto_err), 32'd1);
        cpu_we = 1'b1;
        #2;
        ctrl_reset = 1'b0;
        #1;
        check("async rst stall", 32'(cpu_stall), 32'd0);
        check("async rst rf_we", 32'(rf_we), 32'd0);
        check("async rst wreg", 32'(rf_wreg), 32'd0);
        check("async rst perr", 32'(proto_err), 32'd0);
        do_reset();

        // Randomized run against the model
        rb = 0;
        rsw = 16'h0000;
        burst = 0;
        for (int i = 0; i < 2000; i++) begin
            logic [4:0] rwreg;
            if ($urandom_range(0, 299) == 0) do_reset();
            if ($urandom_range(0, 19) == 0) rsw = 16'($urandom);
            if ($urandom_range(0, 29) == 0) rb = !rb;
            if ($urandom_range(0, 49) == 0) burst = 12;
            if (burst > 0) begin
                rwe = 1;
                burst--;
            end else if (m_stall) begin
                rwe = ($urandom_range(0, 19) == 0);
            end else begin
                rwe = ($urandom_range(0, 2) == 0);
            end
            rwreg = ($urandom_range(0, 3) == 0) ? 5'(26 + $urandom_range(0, 2))
                                                 : 5'($urandom_range(0, 31));
            step(rwe, rwreg, $urandom, rsw, rb);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
